// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serial transmitter arbiter.
package ser_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITSTART,
        PORT,
        LEN,
        DATA,
        DONE
    } state_e;

    localparam int   PORT_W     = 2;
    localparam int   LEN_W      = 4;
    localparam int   CNT_W      = 4;
    localparam logic IDLE_LEVEL = 1'b1;

    // Index of the (single) set bit of a one-hot vector of up to 8 bits.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ser_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around, returned one-hot together with a valid flag.
module rr_picker
    import ser_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o,
    output logic             valid_o
);

    // Scan the requests cyclically starting from the pointer.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one serial transmitter
// between N serial sources. Parses start bit, port and length to find the
// end of the granted frame. Optional build macro SER_ARB_TIMEOUT_EN releases
// a grant whose source never sends a start bit.
module ser_tx_arbiter
    import ser_arb_pkg::*;
#(
    parameter int N = 4
`ifdef SER_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     serIn,
    output logic [N-1:0]     grant,
    output logic             serMuxOut,
    output logic             busy,
    output logic             frameDone,
    output logic [LEN_W-1:0] curLen
);

    localparam int               PTR_W     = $clog2(N);
    localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

    state_e             state_q;
    logic [N-1:0]       grant_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic               done_q;
`ifdef SER_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]   wait_q;
`endif

    logic [N-1:0]       pick;
    logic               pick_valid;
    logic               ser_bit;
    logic [LEN_W-1:0]   len_shift_d;
    logic [2:0]         grant_idx;
    logic [PTR_W-1:0]   ptr_next_d;

    rr_picker #(.N(N), .PTR_W(PTR_W)) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    // Zero-latency mux: the transmitter and the parser see the same bit.
    assign ser_bit     = (grant_q == '0) ? IDLE_LEVEL : |(grant_q & serIn);
    assign len_shift_d = {len_q[LEN_W-2:0], ser_bit};
    assign grant_idx   = onehot_to_idx(8'(grant_q));
    assign ptr_next_d  = PTR_W'((int'(grant_idx) + 1) % N);

    // Frame sequencer: arbitration, header parsing and data bit counting.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == DONE) begin
                // Completion is not gated by the bit-rate enable.
                done_q  <= 1'b1;
                grant_q <= '0;
                ptr_q   <= ptr_next_d;
                state_q <= IDLE;
            end else if (clkEn) begin
                case (state_q)
                    IDLE: begin
                        if (pick_valid) begin
                            grant_q <= pick;
                            state_q <= WAITSTART;
`ifdef SER_ARB_TIMEOUT_EN
                            wait_q  <= '0;
`endif
                        end
                    end
                    WAITSTART: begin
                        if (!ser_bit) begin
                            state_q <= PORT;
                            cnt_q   <= '0;
                        end
`ifdef SER_ARB_TIMEOUT_EN
                        else if (wait_q == TIMEOUT_LAST) begin
                            // Stalled source: give the line away without a frameDone.
                            grant_q <= '0;
                            ptr_q   <= ptr_next_d;
                            state_q <= IDLE;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
`endif
                    end
                    PORT: begin
                        if (cnt_q == PORT_LAST) begin
                            state_q <= LEN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    LEN: begin
                        len_q <= len_shift_d;
                        if (cnt_q == LEN_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (len_shift_d == '0) ? DONE : DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        // len_q is at least 1 here, so len_q-1 never wraps.
                        if (cnt_q == len_q - 1'b1) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign grant     = grant_q;
    assign serMuxOut = ser_bit;
    assign busy      = (state_q != IDLE);
    assign frameDone = done_q;
    assign curLen    = len_q;

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Scoreboard bench for ser_tx_arbiter: a driver serialises frames for the
// granted source and queues the expected length and bit-time count; a monitor
// checks arbitration against a round-robin model and pops on frameDone.
module tb_ser_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         clkEn;
    logic [N-1:0] req;
    logic [N-1:0] serIn;
    logic [N-1:0] grant;
    logic         serMuxOut;
    logic         busy;
    logic         frameDone;
    logic [3:0]   curLen;

    ser_tx_arbiter #(
        .N(N)
`ifdef SER_ARB_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clkEn     (clkEn),
        .req       (req),
        .serIn     (serIn),
        .grant     (grant),
        .serMuxOut (serMuxOut),
        .busy      (busy),
        .frameDone (frameDone),
        .curLen    (curLen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int t;
        bit timeout;
    } exp_t;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   done_cnt  = 0;
    int   to_cnt    = 0;
    int   model_ptr = 0;
    int   pre_cfg[N], port_cfg[N], len_cfg[N], data_cfg[N];
    bit   auto_drop = 0;
    bit   rand_mode = 0;
    int   en_mode   = 1;
    int   sent      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Round-robin rule: first requester at or after the pointer, cyclically.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Driver: clkEn pattern, random idle lines, frame bits for the granted source.
    initial begin : driver
        bit bits[$];
        bit active;
        int src, en_ph;
        active = 0; src = 0; en_ph = 0;
        serIn = '1;
        clkEn = 1'b0;
        forever begin
            @(negedge clk);
            case (en_mode)
                0:       clkEn = ($urandom_range(0, 9) < 7);
                1:       clkEn = 1'b1;
                default: begin clkEn = (en_ph == 0); en_ph = (en_ph + 1) % 4; end
            endcase
            if (active && grant == '0) active = 0;
            if (!active && grant != '0) begin
                src = oh_idx(grant);
                if (rand_mode) begin
                    pre_cfg[src]  = $urandom_range(0, 3);
                    port_cfg[src] = $urandom_range(0, 3);
                    len_cfg[src]  = $urandom_range(0, 15);
                    data_cfg[src] = $urandom_range(0, 65535);
                end
                bits.delete();
                for (int i = 0; i < pre_cfg[src]; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
                for (int i = 1; i >= 0; i--) bits.push_back(port_cfg[src][i]);
                for (int i = 3; i >= 0; i--) bits.push_back(len_cfg[src][i]);
                for (int i = len_cfg[src] - 1; i >= 0; i--) bits.push_back(data_cfg[src][i]);
                sb.push_back('{len: len_cfg[src], t: pre_cfg[src] + 7 + len_cfg[src],
                               timeout: (pre_cfg[src] >= TIMEOUT)});
                sent = 0;
                active = 1;
                serIn[src] = 1'b1;
                if (auto_drop) req[src] = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                if (!active || s != src) serIn[s] = 1'($urandom_range(0, 1));
            end
            if (active && clkEn) begin
                if (bits.size() > 0) begin
                    serIn[src] = bits.pop_front();
                    sent++;
                end else begin
                    serIn[src] = 1'b1;
                end
            end
            if (rand_mode) begin
                for (int s = 0; s < N; s++) begin
                    if (!req[s] && !(active && s == src) && $urandom_range(0, 7) == 0) req[s] = 1'b1;
                end
            end
        end
    end

    // Monitor: arbitration model, grant stability, scoreboard pop on frameDone.
    initial begin : monitor
        logic [N-1:0] g_last, req_e;
        bit           in_frame, en_e, rst_e;
        int           cur, en_cnt, p;
        exp_t         e;
        g_last = '0; in_frame = 0; cur = 0; en_cnt = 0;
        forever begin
            @(posedge clk);
            en_e = clkEn; rst_e = rst; req_e = req;
            #1;
            if (rst_e) begin
                model_ptr = 0;
                sb.delete();
                in_frame = 0;
            end else begin
                if (in_frame && en_e && !frameDone) en_cnt++;
                if (g_last == '0) begin
                    p = en_e ? model_pick(req_e, model_ptr) : -1;
                    check("arb_grant", grant, (p < 0) ? 0 : (1 << p));
                    check("spurious_done", frameDone, 0);
                    if (p >= 0) begin
                        in_frame = 1; cur = p; en_cnt = 0;
                        grant_log.push_back(int'(grant));
                    end
                end else if (frameDone) begin
                    check("done_in_frame", in_frame, 1);
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        check("cur_len", curLen, e.len);
                        check("frame_bit_times", en_cnt, e.t);
                        check("frame_timeout_flag", 0, e.timeout);
                    end
                    check("grant_after_done", grant, 0);
                    model_ptr = (cur + 1) % N;
                    in_frame = 0;
                    done_cnt++;
                end else if (grant == '0) begin
`ifdef SER_ARB_TIMEOUT_EN
                    if (sb.size() == 0) begin
                        check("sb_nonempty_to", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        check("timeout_expected", e.timeout, 1);
                        check("timeout_bit_times", en_cnt, TIMEOUT);
                    end
                    model_ptr = (cur + 1) % N;
                    to_cnt++;
`else
                    check("grant_dropped", grant, 1 << cur);
`endif
                    in_frame = 0;
                end else begin
                    check("grant_stable", grant, 1 << cur);
                end
            end
            check("busy", busy, (grant != '0));
            check("ser_mux", serMuxOut, (grant == '0) ? 1'b1 : serIn[oh_idx(grant)]);
            g_last = grant;
        end
    end

    task automatic wait_done(input string name, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        check(name, done_cnt, target);
    endtask

    task automatic wait_grant(input string name, input int budget);
        for (int i = 0; i < budget && grant == '0; i++) @(negedge clk);
        check(name, (grant != '0), 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; req = '0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic set_cfg(input int s, input int pre, input int port, input int len, input int data);
        pre_cfg[s] = pre; port_cfg[s] = port; len_cfg[s] = len; data_cfg[s] = data;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : directed
        int base;
        rst = 1'b1; req = '0;
        for (int s = 0; s < N; s++) set_cfg(s, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frameDone, 0);
        check("rst_curlen", curLen, 0);
        check("rst_sermux", serMuxOut, 1);
        rst = 1'b0;

        // Single request from source 1, len 3, data 101.
        auto_drop = 1;
        set_cfg(1, 0, 2, 3, 5);
        req = 4'b0010;
        wait_done("t1_done", 1, 200);
        check("t1_grant_src", grant_log[grant_log.size() - 1], 4'b0010);
        check("t1_grant_idle", grant, 0);

        // All four requesting continuously with len=1 frames.
        do_reset();
        auto_drop = 0;
        grant_log.delete();
        base = done_cnt;
        req = '1;
        for (int i = 0; i < 400 && grant_log.size() < 5; i++) @(negedge clk);
        req = '0;
        check("t2_grants_seen", grant_log.size(), 5);
        wait_done("t2_done", base + 5, 200);
        if (grant_log.size() >= 5) begin
            check("t2_order0", grant_log[0], 4'b0001);
            check("t2_order1", grant_log[1], 4'b0010);
            check("t2_order2", grant_log[2], 4'b0100);
            check("t2_order3", grant_log[3], 4'b1000);
            check("t2_order4", grant_log[4], 4'b0001);
        end

        // Zero-length frame.
        auto_drop = 1;
        set_cfg(0, 1, 3, 0, 0);
        base = done_cnt;
        req = 4'b0001;
        wait_done("t3_done", base + 1, 200);

        // Enable toggling 1-in-4 with a len=2 frame from source 1.
        en_mode = 2;
        set_cfg(1, 2, 1, 2, 2);
        base = done_cnt;
        req = 4'b0010;
        wait_done("t4_done", base + 1, 400);
        en_mode = 0;

        // Reset in the middle of DATA while source 2 holds the grant.
        set_cfg(2, 0, 2, 10, 16'h2a5);
        req = 4'b0100;
        wait_grant("t5_grant", 100);
        for (int i = 0; i < 200 && sent < 10; i++) @(negedge clk);
        check("t5_grant_mid", grant, 4'b0100);
        check("t5_busy_mid", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_sermux", serMuxOut, 1);
        check("t5_curlen", curLen, 0);
        check("t5_done", frameDone, 0);
        rst = 1'b0;
        set_cfg(0, 0, 0, 2, 1);
        set_cfg(3, 1, 3, 4, 9);
        base = done_cnt;
        req = 4'b1001;
        wait_grant("t5_regrant", 100);
        check("t5_ptr_zero", grant, 4'b0001);
        wait_done("t5_after", base + 2, 400);

`ifdef SER_ARB_TIMEOUT_EN
        // Source 2 never sends a start bit; source 3 is served next.
        set_cfg(2, 40, 0, 1, 0);
        base = to_cnt;
        req = 4'b0100;
        wait_grant("t6_grant", 100);
        check("t6_src2", grant, 4'b0100);
        req = 4'b1001;
        for (int i = 0; i < 200 && to_cnt == base; i++) @(negedge clk);
        check("t6_timeout", to_cnt, base + 1);
        wait_grant("t6_next", 100);
        check("t6_src3", grant, 4'b1000);
        base = done_cnt;
        wait_done("t6_drain", base + 2, 400);
`endif

        // Randomised traffic against the model.
        rand_mode = 1;
        base = done_cnt;
        wait_done("rand_done", base + 30, 30000);
        rand_mode = 0;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check("final_idle", busy, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ser_tx_arbiter.md
Name: ser_tx_arbiter

Overview:
- Round-robin arbiter and frame sequencer that shares one serial transmitter between N serial sources.
- Grants one requester at a time and muxes that requester's serial line onto the transmitter's serial input.
- Parses the frame header (start bit, 2-bit port, 4-bit length) to find the frame end, then releases the grant.
- Sits directly upstream of the serial transmitter and uses the same clkEn bit-rate enable.

Parameters:
- N, 4, number of requesting serial sources (2..8).
- TIMEOUT, 15, enabled-cycle limit for a start bit after grant (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clkEn  input  1  bit-rate enable; state advances and bits are sampled only when high.
- req  input  N  per-source request, level; held until grant seen.
- serIn  input  N  per-source serial lines, idle-high.
- grant  output  N  one-hot registered grant.
- serMuxOut  output  1  serial line to the transmitter; equals serIn[g] while grant[g] is high, else 1.
- busy  output  1  high in any state other than IDLE.
- frameDone  output  1  one-clk pulse when the granted frame completes.
- curLen  output  4  latched length field of the current frame.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: grant=0, busy=0, frameDone=0, curLen=0, state=IDLE, rr pointer=0, bit counter=0. serMuxOut=1 follows from grant=0.
- Frame format, MSB first: start bit 0, then port[1:0], then len[3:0], then len data bits.
- States and transitions (all taken only on cycles with clkEn=1):
  - IDLE: if req is non-zero, pick the first set req at or after the pointer, cyclically. On the next clk, grant=onehot(pick) and state=WAITSTART. If req=0, stay.
  - WAITSTART: a sampled bit of 0 goes to PORT with counter=0. A sampled 1 stays.
  - PORT: 2 bits; after the 2nd bit go to LEN.
  - LEN: 4 bits shifted into curLen. After the 4th bit: if len=0 go to DONE, else go to DATA with counter=0.
  - DATA: count len bits. After bit len go to DONE.
  - DONE: on the next clk (clkEn ignored) set frameDone=1 for one cycle, grant=0, pointer=pick+1 mod N, state=IDLE.
- When clkEn=0, all registers hold. The DONE exit is the only exception.
- serMuxOut is combinational from grant and serIn: zero latency, so the transmitter sees the same bits on the same cycle.
- Dropping req after grant has no effect. The frame runs to completion.
- The grant is never re-evaluated mid-frame. New requests wait for IDLE.
- Fairness: after serving source k, source k has the lowest priority in the next arbitration.
- Simultaneous frameDone and a new req: arbitration happens in IDLE on the next enabled cycle. There is no back-to-back grant in the DONE cycle.
- rst mid-frame: everything returns to reset values on the next clk, serMuxOut returns to 1 immediately after, and the pointer returns to 0.
- Counter width is 4 bits. len=15 gives 15 data bits with no wrap.

Optional Feature:
- Macro SER_ARB_TIMEOUT_EN.
- Defined: a 4-bit wait counter increments on enabled cycles in WAITSTART. If it reaches TIMEOUT without a start bit, grant drops, the pointer advances past the stalled source, state returns to IDLE, and frameDone is not pulsed.
- Undefined: WAITSTART waits indefinitely; the counter and TIMEOUT are unused.

Decomposition:
- Package ser_arb_pkg holds:
  - the state enum {IDLE, WAITSTART, PORT, LEN, DATA, DONE};
  - constants PORT_W=2, LEN_W=4, IDLE_LEVEL=1'b1.
- Sub-module rr_picker: combinational; inputs req and pointer; outputs one-hot pick and valid.
- The FSM, counters and mux stay in the top module.

Test Plan:
1. Single request, req=4'b0010, source 1 sends 0,10,0011 then data 101 -> grant=0010 one clk after the enabled cycle. serMuxOut mirrors serIn[1]. curLen=3. frameDone pulses after the 3rd data bit, then grant=0.
2. All four requesting continuously, each sending len=1 frames -> grant order 0001, 0010, 0100, 1000, 0001.
3. len=0 frame, header 0,11,0000 -> DONE right after the last LEN bit, with frameDone one clk later.
4. clkEn toggling 1-in-4, len=2 frame -> state advances only on enabled cycles. Total enabled cycles from grant to frameDone is 1+2+4+2 plus preceding idle-high bits.
5. rst asserted mid-DATA with grant=0100 -> next clk: grant=0, busy=0, serMuxOut=1, curLen=0. The next arbitration starts from source 0.
6. SER_ARB_TIMEOUT_EN defined with source 2 granted holding its line at 1 -> grant drops after 15 enabled cycles with no frameDone. Source 3 is served next.
